noc_packet_receiver: RTL and testbench

Sink and checker at a router local port, consuming the 40-bit flit stream produced by the packet generator. It parses header, payload and tail flits, verifies that the packet is addressed to this node, and checks the flit sequence. It reports each good packet with its source address and payload length, and keeps packet and error statistics for the test harness.

---
 rtl/noc_packet_receiver.sv | 170 +++++++++++++++++
 tb/tb_noc_packet_receiver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_receiver.sv
// Local-port flit sink: parses header/payload/tail, checks destination and flit order, counts packets/errors.
// Optional build macro PKT_RX_CHECKSUM_EN adds a running-XOR checksum compared against the tail.
module noc_packet_receiver #(
    parameter int         FW          = 40,
    parameter logic [3:0] LOC_X       = 4'd2,
    parameter logic [3:0] LOC_Y       = 4'd1,
    parameter logic [3:0] LOC_Z       = 4'd4,
    parameter int         MAX_PAYLOAD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] flit_in,
    input  logic          flit_valid,
    output logic          flit_ready,
    output logic          pkt_valid,
    output logic [3:0]    pkt_src_x,
    output logic [3:0]    pkt_src_y,
    output logic [3:0]    pkt_src_z,
    output logic [3:0]    pkt_len,
    output logic          err_misroute,
    output logic          err_seq,
    output logic [15:0]   rx_pkt_cnt,
    output logic [15:0]   rx_err_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BODY = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] T_HDR  = 2'b11;
    localparam logic [1:0] T_PAY  = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b01;

    localparam logic [3:0] MAX_LEN = 4'(MAX_PAYLOAD);

    logic [1:0]  state_q, state_d;
    logic [3:0]  src_x_q, src_x_d;
    logic [3:0]  src_y_q, src_y_d;
    logic [3:0]  src_z_q, src_z_d;
    logic [3:0]  len_q, len_d;
    logic        mis_q, mis_d;
    logic        seq_q, seq_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [1:0]  ftype;
    logic        accept;
    logic        dst_match;
    logic        tail_ok;

    assign ftype     = flit_in[FW-1:FW-2];
    assign accept    = flit_valid && flit_ready;
    assign dst_match = (flit_in[25:22] == LOC_X) && (flit_in[21:18] == LOC_Y) &&
                       (flit_in[17:14] == LOC_Z);

    // Low flit bits only matter to the optional checksum.
    logic unused_flit_bits;
    assign unused_flit_bits = ^flit_in[13:0];

`ifdef PKT_RX_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    assign tail_ok = (flit_in[15:0] == csum_q);
`else
    assign tail_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        src_z_d = src_z_q;
        len_d   = len_q;
        mis_d   = 1'b0;
        seq_d   = 1'b0;
`ifdef PKT_RX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (accept && ftype == T_HDR) begin
            // A header cutting into an open packet is a sequence error; it still starts a new packet.
            seq_d   = (state_q == S_BODY);
            mis_d   = !dst_match && (state_q != S_BODY);
            src_x_d = flit_in[37:34];
            src_y_d = flit_in[33:30];
            src_z_d = flit_in[29:26];
            len_d   = 4'd0;
            state_d = dst_match ? S_BODY : S_DROP;
`ifdef PKT_RX_CHECKSUM_EN
            csum_d  = flit_in[15:0];
`endif
        end else if (accept && (ftype == T_PAY || ftype == T_TAIL)) begin
            case (state_q)
                S_IDLE: seq_d = 1'b1;
                S_BODY: begin
                    if (ftype == T_PAY) begin
                        if (len_q == MAX_LEN) begin
                            seq_d   = 1'b1;
                            state_d = S_DROP;
                        end else begin
                            len_d = len_q + 4'd1;
`ifdef PKT_RX_CHECKSUM_EN
                            csum_d = csum_q ^ flit_in[15:0];
`endif
                        end
                    end else if (tail_ok) begin
                        state_d = S_DONE;
                    end else begin
                        seq_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (ftype == T_TAIL) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q + ((state_q == S_DONE) ? 16'd1 : 16'd0);
        err_cnt_d = err_cnt_q;
        if ((mis_d || seq_d) && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            src_x_q   <= 4'd0;
            src_y_q   <= 4'd0;
            src_z_q   <= 4'd0;
            len_q     <= 4'd0;
            mis_q     <= 1'b0;
            seq_q     <= 1'b0;
            pkt_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            src_x_q   <= src_x_d;
            src_y_q   <= src_y_d;
            src_z_q   <= src_z_d;
            len_q     <= len_d;
            mis_q     <= mis_d;
            seq_q     <= seq_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef PKT_RX_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) csum_q <= 16'd0;
        else      csum_q <= csum_d;
    end
`endif

    assign flit_ready   = (state_q != S_DONE);
    assign pkt_valid    = (state_q == S_DONE);
    assign pkt_src_x    = src_x_q;
    assign pkt_src_y    = src_y_q;
    assign pkt_src_z    = src_z_q;
    assign pkt_len      = len_q;
    assign err_misroute = mis_q;
    assign err_seq      = seq_q;
    assign rx_pkt_cnt   = pkt_cnt_q;
    assign rx_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Directed bench for noc_packet_receiver: scoreboard of expected packets, immediate-assertion checks.
module tb_noc_packet_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] flit_in = 40'd0;
    logic        flit_valid = 1'b0;
    logic        flit_ready;
    logic        pkt_valid;
    logic [3:0]  pkt_src_x, pkt_src_y, pkt_src_z, pkt_len;
    logic        err_misroute, err_seq;
    logic [15:0] rx_pkt_cnt, rx_err_cnt;

    noc_packet_receiver dut (
        .clk(clk), .rst(rst),
        .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .pkt_valid(pkt_valid),
        .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y), .pkt_src_z(pkt_src_z),
        .pkt_len(pkt_len),
        .err_misroute(err_misroute), .err_seq(err_seq),
        .rx_pkt_cnt(rx_pkt_cnt), .rx_err_cnt(rx_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pkt_seen = 0;
    logic [15:0] sb_q[$];
    logic [15:0] csum = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every good packet must match the oldest scoreboard entry {src_x,src_y,src_z,len}.
    always @(negedge clk) begin
        if (rst && pkt_valid === 1'b1) begin
            pkt_seen++;
            check("done_ready_low", 32'(flit_ready), 32'd0);
            if (sb_q.size() == 0) check("unexpected_pkt", 32'(sb_q.size()), 32'd1);
            else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                check("pkt_fields", {16'd0, pkt_src_x, pkt_src_y, pkt_src_z, pkt_len}, {16'd0, e});
                $display("pkt src=(%0d,%0d,%0d) len=%0d", pkt_src_x, pkt_src_y, pkt_src_z, pkt_len);
            end
        end
    end

    task automatic send(input logic [39:0] f);
        int n;
        @(negedge clk);
        flit_in = f;
        flit_valid = 1'b1;
        n = 0;
        while (flit_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("ready_timeout", 32'(flit_ready), 32'd1);
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
        flit_in = 40'd0;
    endtask

    task automatic send_hdr(input logic [3:0] sx, sy, sz, dx, dy, dz);
        logic [39:0] f;
        f = {2'b11, sx, sy, sz, dx, dy, dz, 14'h0};
        csum = f[15:0];
        send(f);
    endtask

    task automatic send_pay(input logic [15:0] d);
        logic [39:0] f;
        f = {2'b10, 6'd0, 16'(d * 16'd7), d};
        csum = csum ^ d;
        send(f);
    endtask

    task automatic send_tail();
        send({2'b01, 22'd0, csum});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen0;
        #12;
        check("rst_ready", 32'(flit_ready), 32'd1);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_counts", {rx_pkt_cnt, rx_err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Good packet, two payloads
        sb_q.push_back({4'd1, 4'd3, 4'd0, 4'd2});
        send_hdr(4'd1, 4'd3, 4'd0, 4'd2, 4'd1, 4'd4);
        send_pay(16'h1234);
        send_pay(16'hBEEF);
        send_tail();
        check("t1_pkt_valid", 32'(pkt_valid), 32'd1);
        check("t1_ready_low", 32'(flit_ready), 32'd0);
        tick();
        check("t1_pkt_cnt", 32'(rx_pkt_cnt), 32'd1);
        check("t1_pkt_valid_gone", 32'(pkt_valid), 32'd0);
        check("t1_len_hold", 32'(pkt_len), 32'd2);

        // Misrouted packet
        send_hdr(4'd5, 4'd5, 4'd5, 4'd6, 4'd1, 4'd4);
        check("t2_misroute", 32'(err_misroute), 32'd1);
        check("t2_src_capt", {20'd0, pkt_src_x, pkt_src_y, pkt_src_z}, 32'h555);
        send_pay(16'h0001);
        check("t2_misroute_pulse", 32'(err_misroute), 32'd0);
        send_tail();
        check("t2_no_pkt", 32'(pkt_valid), 32'd0);
        check("t2_err_cnt", 32'(rx_err_cnt), 32'd1);
        $display("t2 misroute err_cnt=%0d", rx_err_cnt);

        // Payload in IDLE, then a good packet
        send_pay(16'h00AA);
        check("t3_seq", 32'(err_seq), 32'd1);
        sb_q.push_back({4'd7, 4'd0, 4'd9, 4'd1});
        send_hdr(4'd7, 4'd0, 4'd9, 4'd2, 4'd1, 4'd4);
        check("t3_seq_pulse", 32'(err_seq), 32'd0);
        send_pay(16'h5A5A);
        send_tail();
        tick();
        check("t3_counts", {rx_pkt_cnt, rx_err_cnt}, {16'd2, 16'd2});

        // Payload overflow
        send_hdr(4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd4);
        for (int i = 0; i < 4; i++) send_pay(16'(i + 1));
        check("t4_no_seq_at_max", 32'(err_seq), 32'd0);
        send_pay(16'h0005);
        check("t4_seq_overflow", 32'(err_seq), 32'd1);
        send_tail();
        check("t4_no_pkt", 32'(pkt_valid), 32'd0);
        check("t4_len", 32'(pkt_len), 32'd4);
        check("t4_err_cnt", 32'(rx_err_cnt), 32'd3);

        // Zero-payload packet
        sb_q.push_back({4'd2, 4'd2, 4'd2, 4'd0});
        send_hdr(4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd4);
        send_tail();
        check("zp_pkt_valid", 32'(pkt_valid), 32'd1);
        tick();
        check("zp_pkt_cnt", 32'(rx_pkt_cnt), 32'd3);

        // Reset mid-packet
        send_hdr(4'd8, 4'd8, 4'd8, 4'd2, 4'd1, 4'd4);
        send_pay(16'h0F0F);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_outs", {pkt_src_x, pkt_src_y, pkt_src_z, pkt_len, 13'd0,
                              pkt_valid, err_misroute, err_seq}, 32'd0);
        check("t5_rst_cnts", {rx_pkt_cnt, rx_err_cnt}, 32'd0);
        check("t5_rst_ready", 32'(flit_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        seen0 = pkt_seen;
        sb_q.push_back({4'd4, 4'd5, 4'd6, 4'd1});
        send_hdr(4'd4, 4'd5, 4'd6, 4'd2, 4'd1, 4'd4);
        send_pay(16'hC0DE);
        send_tail();
        tick();
        tick();
        check("t5_one_pkt", 32'(pkt_seen - seen0), 32'd1);
        check("t5_pkt_cnt", 32'(rx_pkt_cnt), 32'd1);

        // Error counter saturation
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 65535; i++) send_pay(16'h0001);
        check("t6_err_full", 32'(rx_err_cnt), 32'h0000FFFF);
        send_pay(16'h0002);
        check("t6_err_sat", 32'(rx_err_cnt), 32'h0000FFFF);
        check("t6_seq_still", 32'(err_seq), 32'd1);
        $display("t6 err_cnt=%0h", rx_err_cnt);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
